// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding, grant
// identifiers and the word-alignment helper used when latching addresses.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_CPU = 2'd1,
        BUSY_DBG = 2'd2
    } arb_state_t;

    typedef enum logic {
        CPU = 1'b0,
        DBG = 1'b1
    } grant_t;

    localparam int STAT_WIDTH = 16;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over
// increment and the count sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the CPU MEM stage and the debug/loader port
// share one memory port, round-robin on ties, one transaction at a time.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_stall_o,

    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_ack_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,

    input  logic        stat_clr_i,
    output logic [15:0] stall_cnt_o
);

    arb_state_t  state_q, state_d;
    grant_t      last_grant;
    logic        grant_cpu, grant_dbg, done;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        cpu_ack_q, dbg_ack_q;
    logic [31:0] cpu_rdata_q, dbg_rdata_q;

    // Grants are suppressed while an ack is out so IDLE always lasts a cycle.
    always_comb begin
        state_d   = state_q;
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!(cpu_ack_q || dbg_ack_q)) begin
                    if (cpu_req_i && dbg_req_i) begin
                        grant_cpu = (last_grant == DBG);
                        grant_dbg = (last_grant == CPU);
                    end else begin
                        grant_cpu = cpu_req_i;
                        grant_dbg = dbg_req_i;
                    end
                end
                if (grant_cpu) begin
                    state_d = BUSY_CPU;
                end else if (grant_dbg) begin
                    state_d = BUSY_DBG;
                end
            end
            BUSY_CPU, BUSY_DBG: begin
                if (mem_ack_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_grant <= DBG;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            state_q <= state_d;
            if (grant_cpu) begin
                last_grant <= CPU;
                lat_we     <= cpu_we_i;
                lat_addr   <= word_align(cpu_addr_i);
                lat_wdata  <= cpu_wdata_i;
            end else if (grant_dbg) begin
                last_grant <= DBG;
                lat_we     <= dbg_we_i;
                lat_addr   <= word_align(dbg_addr_i);
                lat_wdata  <= dbg_wdata_i;
            end
        end
    end

    // Completion goes back to whichever port owned the access, even if that
    // requester has already dropped its request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            cpu_ack_q <= done && (state_q == BUSY_CPU);
            dbg_ack_q <= done && (state_q == BUSY_DBG);
            if (done && !lat_we && (state_q == BUSY_CPU)) begin
                cpu_rdata_q <= mem_rdata_i;
            end
            if (done && !lat_we && (state_q == BUSY_DBG)) begin
                dbg_rdata_q <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = (state_q != IDLE);
    assign mem_we_o    = lat_we;
    assign mem_addr_o  = lat_addr;
    assign mem_wdata_o = lat_wdata;

    assign cpu_ack_o   = cpu_ack_q;
    assign dbg_ack_o   = dbg_ack_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign dbg_rdata_o = dbg_rdata_q;
    assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;

    sat_counter #(
        .WIDTH(STAT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (stat_clr_i),
        .inc   (cpu_stall_o),
        .count (stall_cnt_o)
    );

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports: clk_i  in  1  clock, all state updates on its rising edge; rst_i  in  1  asynchronous active-high reset.
REQ-002 It SHALL provide the CPU MEM-stage port: cpu_req_i in 1 access request; cpu_we_i in 1 write (1) / read (0); cpu_addr_i in 32 byte address; cpu_wdata_i in 32 write data; cpu_rdata_o out 32 read data; cpu_ack_o out 1 one-cycle completion pulse; cpu_stall_o out 1 pipeline stall request.
REQ-003 It SHALL provide the debug/loader port: dbg_req_i in 1; dbg_we_i in 1; dbg_addr_i in 32; dbg_wdata_i in 32; dbg_rdata_o out 32; dbg_ack_o out 1, with the same meanings as the CPU port.
REQ-004 It SHALL provide the memory port: mem_req_o out 1; mem_we_o out 1; mem_addr_o out 32, word-aligned; mem_wdata_o out 32; mem_rdata_i in 32; mem_ack_i in 1 completion, valid in any cycle mem_req_o=1.
REQ-005 It SHALL provide statistics: stat_clr_i in 1 synchronous clear; stall_cnt_o out 16 saturating count of stall cycles.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY_CPU, BUSY_DBG.
REQ-007 In IDLE with exactly one requester, the FSM SHALL go to that requester's BUSY state on the next edge.
REQ-008 In IDLE with both requesters, the FSM SHALL grant the port not granted last (round-robin), tracked in register last_grant.
REQ-009 On grant, the FSM SHALL latch we, {addr[31:2],2'b00} and wdata of the winner; mem_* outputs SHALL be driven only from these latched values.
REQ-010 mem_req_o SHALL be 1 exactly while in BUSY_CPU or BUSY_DBG.
REQ-011 On a cycle with mem_req_o=1 and mem_ack_i=1, the FSM SHALL, at the next edge: return to IDLE; register mem_rdata_i into the owner's rdata output for reads, else hold it; pulse the owner's ack for one cycle.
REQ-012 Minimum latency SHALL be request at edge N, grant at N+1, ack high during cycle N+2 when mem_ack_i is high in the first BUSY cycle.
REQ-013 A new grant SHALL NOT be issued in the cycle ack is high; IDLE is held at least one cycle between transactions.
REQ-014 cpu_stall_o SHALL equal cpu_req_i AND NOT cpu_ack_o (combinational).
REQ-015 Requesters SHALL hold req and fields stable until ack. If req is dropped mid-transaction, the memory access SHALL still complete, and ack SHALL still pulse.
REQ-016 stall_cnt_o SHALL increment by 1 per cycle cpu_stall_o=1, saturate at 16'hFFFF, and clear to 0 on stat_clr_i; clear SHALL win over increment.
REQ-017 The memory port SHALL never be granted to both requesters; ownership changes only via IDLE.

Reset
REQ-018 On rst_i=1, the block SHALL immediately set: state=IDLE; last_grant=DBG, so the CPU wins the first tie; mem_req_o=0; cpu_ack_o=dbg_ack_o=0; cpu_rdata_o=dbg_rdata_o=0; latched fields=0; stall_cnt_o=0.
REQ-019 Reset mid-transaction SHALL abandon the access with no ack pulse; a memory ack arriving after reset SHALL be ignored.

Structure
REQ-020 The state encoding (2-bit) and the grant identifiers CPU=0/DBG=1 SHALL reside in the shared CPU package.
REQ-021 The saturating counter SHALL be one sub-module, sat_counter, with parameterised width; everything else SHALL be flat.

Verification
REQ-022 CPU read of addr 0x00 with memory word 5 and mem_ack_i tied high -> cpu_ack_o pulses 2 cycles after request, cpu_rdata_o=5, stall_cnt_o=2.
REQ-023 Simultaneous CPU write 0x04=7 and debug write 0x08=9 after reset -> CPU served first, then debug; mem_addr_o sequence 0x04 then 0x08; no overlap.
REQ-024 Both requesters held continuously for 6 transactions -> grants alternate CPU,DBG,CPU,DBG,CPU,DBG.
REQ-025 mem_ack_i delayed 3 cycles, CPU read of addr 0x0D -> mem_addr_o=0x0C, mem_req_o high 4 cycles, cpu_stall_o high until the ack cycle.
REQ-026 rst_i asserted during BUSY_DBG -> mem_req_o low immediately, no dbg_ack_o, state IDLE.
REQ-027 Force 65540 stall cycles -> stall_cnt_o=16'hFFFF; assert stat_clr_i alongside a stall -> 0.
